ce_seq: RTL and testbench

- Sequencer/arbiter for one shared multi-cycle custom engine (CE) port.
- Two requesters share the port:
  - Core pipeline, at E stage, with hold-based stall.
  - Auxiliary requester (EJTAG/debug or DMA-style master), with req/gnt handshake.
- Sits between the core's CE operand/op buffers and the engine.
- Handles request arbitration, operand capture, start/done sequencing, core-kill abort, timeout recovery and per-requester result return.

---
 rtl/ce_seq_pkg.sv | 11 +
 rtl/ce_rr_arb.sv | 13 +
 rtl/ce_seq.sv | 102 ++++++++++
 tb/tb_ce_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ce_seq_pkg.sv
// ce_seq_pkg: shared state/owner encodings and defaults for the CE sequencer.
package ce_seq_pkg;
  localparam int DEF_OPW = 12;
  localparam int DEF_DW = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_AUX = 1'b1;
  localparam logic [DEF_DW-1:0] TMO_RES = '0;
endpackage

// File: rtl/ce_rr_arb.sv
// ce_rr_arb: combinational 2-way round-robin between core and aux requests.
module ce_rr_arb
  import ce_seq_pkg::*;
(
  input  logic       i_req_core,
  input  logic       i_req_aux,
  input  logic       i_en,
  input  logic       i_rr_last,
  output logic [1:0] o_gnt
);
  assign o_gnt[0] = i_en & i_req_core & (~i_req_aux | (i_rr_last == OWN_AUX));
  assign o_gnt[1] = i_en & i_req_aux & (~i_req_core | (i_rr_last == OWN_CORE));
endmodule

// File: rtl/ce_seq.sv
// ce_seq: arbitrates core/aux access to one multi-cycle custom engine and
// sequences start, done, kill, timeout and per-requester result return.
module ce_seq
  import ce_seq_pkg::*;
#(
  parameter int OPW     = DEF_OPW,
  parameter int DW      = DEF_DW,
  parameter int TMO_CYC = 64,
  parameter int TMO_W   = 7
) (
  input  logic           SYSCLK,
  input  logic           RESET1,
  input  logic           CORE_REQ_E,
  input  logic [OPW-1:0] CORE_OP_E,
  input  logic [DW-1:0]  CORE_AOP_E,
  input  logic [DW-1:0]  CORE_BOP_E,
  input  logic           CORE_KILL_M,
  output logic           CORE_HOLD,
  output logic [DW-1:0]  CORE_RES,
  output logic           CORE_RES_VLD,
  input  logic           AUX_REQ,
  input  logic [OPW-1:0] AUX_OP,
  input  logic [DW-1:0]  AUX_AOP,
  input  logic [DW-1:0]  AUX_BOP,
  output logic           AUX_GNT,
  output logic [DW-1:0]  AUX_RES,
  output logic           AUX_RES_VLD,
  output logic           CE_START,
  output logic [OPW-1:0] CE_OP,
  output logic [DW-1:0]  CE_AOP,
  output logic [DW-1:0]  CE_BOP,
  input  logic           CE_DONE,
  input  logic [DW-1:0]  CE_RES,
  output logic           CE_ABORT,
  input  logic           ERR_CLR,
  output logic           TMO_ERR
);
  logic [1:0]       r_state;
  logic             r_owner, r_rr_last, r_err;
  logic [TMO_W-1:0] r_cnt;
  logic [OPW-1:0]   r_op;
  logic [DW-1:0]    r_aop, r_bop, r_core_res, r_aux_res;
  logic [1:0]       w_gnt;
  logic             w_busy, w_start, w_done, w_kill, w_tmo, w_end;

  ce_rr_arb u_arb (
    .i_req_core(CORE_REQ_E),
    .i_req_aux (AUX_REQ),
    .i_en      (r_state == S_IDLE),
    .i_rr_last (r_rr_last),
    .o_gnt     (w_gnt)
  );

  // counter is zero only in the first BUSY cycle, which doubles as the start cycle
  assign w_busy  = r_state == S_BUSY;
  assign w_start = w_busy & (r_cnt == '0);
  assign w_done  = w_busy & ~w_start & CE_DONE;
  assign w_kill  = w_busy & (r_owner == OWN_CORE) & CORE_KILL_M;
  assign w_tmo   = w_busy & ~w_done & ~w_kill & (r_cnt == TMO_W'(TMO_CYC - 1));
  assign w_end   = (w_done & ~w_kill) | w_tmo;

  assign CE_START     = w_start;
  assign CE_ABORT     = (w_kill & ~w_done) | w_tmo;
  assign CE_OP        = r_op;
  assign CE_AOP       = r_aop;
  assign CE_BOP       = r_bop;
  assign AUX_GNT      = w_gnt[1];
  assign CORE_RES_VLD = (r_state == S_RESP) & (r_owner == OWN_CORE);
  assign AUX_RES_VLD  = (r_state == S_RESP) & (r_owner == OWN_AUX);
  assign CORE_HOLD    = CORE_REQ_E & ~CORE_RES_VLD;
  assign CORE_RES     = r_core_res;
  assign AUX_RES      = r_aux_res;
  assign TMO_ERR      = r_err;

  always_ff @(posedge SYSCLK) begin
    if (RESET1) begin
      r_state    <= S_IDLE;
      r_owner    <= OWN_CORE;
      r_rr_last  <= OWN_AUX;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_op       <= '0;
      r_aop      <= '0;
      r_bop      <= '0;
      r_core_res <= '0;
      r_aux_res  <= '0;
    end else begin
      if (|w_gnt) begin
        r_owner   <= w_gnt[1] ? OWN_AUX : OWN_CORE;
        r_rr_last <= w_gnt[1] ? OWN_AUX : OWN_CORE;
        r_op      <= w_gnt[1] ? AUX_OP : CORE_OP_E;
        r_aop     <= w_gnt[1] ? AUX_AOP : CORE_AOP_E;
        r_bop     <= w_gnt[1] ? AUX_BOP : CORE_BOP_E;
      end
      r_state <= (|w_gnt | (w_busy & ~w_kill & ~w_end)) ? S_BUSY : w_end ? S_RESP : S_IDLE;
      r_cnt   <= w_busy ? r_cnt + 1'b1 : '0;
      if (w_end & (r_owner == OWN_CORE)) r_core_res <= w_done ? CE_RES : DW'(TMO_RES);
      if (w_end & (r_owner == OWN_AUX)) r_aux_res <= w_done ? CE_RES : DW'(TMO_RES);
      r_err <= w_tmo | (r_err & ~ERR_CLR);
    end
  end
endmodule

// File: tb/tb_ce_seq.sv
// tb_ce_seq: transaction-level randomized check of ce_seq against a
// round-robin / latency / result model kept in the bench.
module tb_ce_seq;
  localparam int OPW = 12, DW = 32, TMO_CYC = 64;

  logic SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  logic           rst, core_req, core_kill, aux_req, ce_done, err_clr;
  logic [OPW-1:0] core_op, aux_op;
  logic [DW-1:0]  core_aop, core_bop, aux_aop, aux_bop, ce_rin;
  logic           core_hold, core_vld, aux_gnt, aux_vld, ce_start, ce_abort, tmo_err;
  logic [DW-1:0]  core_res, aux_res, ce_aop, ce_bop;
  logic [OPW-1:0] ce_op;

  ce_seq dut (
    .SYSCLK(SYSCLK), .RESET1(rst),
    .CORE_REQ_E(core_req), .CORE_OP_E(core_op), .CORE_AOP_E(core_aop), .CORE_BOP_E(core_bop),
    .CORE_KILL_M(core_kill), .CORE_HOLD(core_hold), .CORE_RES(core_res), .CORE_RES_VLD(core_vld),
    .AUX_REQ(aux_req), .AUX_OP(aux_op), .AUX_AOP(aux_aop), .AUX_BOP(aux_bop),
    .AUX_GNT(aux_gnt), .AUX_RES(aux_res), .AUX_RES_VLD(aux_vld),
    .CE_START(ce_start), .CE_OP(ce_op), .CE_AOP(ce_aop), .CE_BOP(ce_bop),
    .CE_DONE(ce_done), .CE_RES(ce_rin), .CE_ABORT(ce_abort),
    .ERR_CLR(err_clr), .TMO_ERR(tmo_err)
  );

  int n_vec = 0, n_err = 0;
  bit rr_aux;
  logic [DW-1:0] exp_core, exp_aux;
  bit exp_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #2;
  endtask

  task automatic cyc_chk(input string tag, input bit s, input bit a, input bit cv, input bit av, input bit g);
    chk({tag, ".start"}, ce_start, s);
    chk({tag, ".abort"}, ce_abort, a);
    chk({tag, ".core_vld"}, core_vld, cv);
    chk({tag, ".aux_vld"}, aux_vld, av);
    chk({tag, ".aux_gnt"}, aux_gnt, g);
    chk({tag, ".hold"}, core_hold, core_req & ~cv);
    chk({tag, ".core_res"}, core_res, exp_core);
    chk({tag, ".aux_res"}, aux_res, exp_aux);
    chk({tag, ".tmo_err"}, tmo_err, exp_err);
  endtask

  task automatic do_reset(input bit mid);
    rst = 1'b1; core_req = 0; aux_req = 0; core_kill = 0; ce_done = 0; err_clr = 0;
    if (mid) begin
      #1;
      chk("rst.no_abort", ce_abort, 0);
    end
    tick();
    rst = 1'b0;
    rr_aux = 1; exp_core = '0; exp_aux = '0; exp_err = 0;
    #1;
    cyc_chk("rst", 0, 0, 0, 0, 0);
    chk("rst.ce_op", ce_op, 0);
    chk("rst.ce_aop", ce_aop, 0);
    chk("rst.ce_bop", ce_bop, 0);
  endtask

  // One arbitration + operation starting in an IDLE cycle with requests already driven.
  // k: CE_DONE cycle counted from the start cycle (=1), 0 = never; kill_at: core kill cycle, 0 = none.
  task automatic txn(input int k, input int kill_at, input bit noise, input logic [DW-1:0] res);
    bit wa, fin, tmo;
    int ka;
    logic [OPW-1:0] eop;
    logic [DW-1:0] ea, eb;
    wa  = aux_req && (!core_req || !rr_aux);
    ka  = wa ? 0 : kill_at;
    eop = wa ? aux_op : core_op;
    ea  = wa ? aux_aop : core_aop;
    eb  = wa ? aux_bop : core_bop;
    fin = 0;
    #1;
    cyc_chk("grant", 0, 0, 0, 0, wa);
    rr_aux = wa;
    for (int c = 1; c <= TMO_CYC && !fin; c++) begin
      tick();
      ce_done   = (c == k) || (c == 1 && noise);
      ce_rin    = (c == k) ? res : $urandom;
      core_kill = (c == ka) || (wa && noise && ($urandom_range(0, 1) == 1));
      #1;
      chk("ce_op", ce_op, eop);
      chk("ce_aop", ce_aop, ea);
      chk("ce_bop", ce_bop, eb);
      if (c == ka) begin
        cyc_chk("kill", 0, c != k, 0, 0, 0);
        fin = 1;
      end else if (c == k || c == TMO_CYC) begin
        tmo = (c != k);
        cyc_chk("busy_end", 0, tmo, 0, 0, 0);
        tick();
        ce_done = 0;
        core_kill = noise && !wa;
        if (wa) exp_aux = tmo ? '0 : res;
        else exp_core = tmo ? '0 : res;
        if (tmo) exp_err = 1;
        #1;
        cyc_chk("resp", 0, 0, !wa, wa, 0);
        fin = 1;
      end else begin
        cyc_chk("busy", c == 1, 0, 0, 0, 0);
      end
    end
    tick();
    ce_done = 0; core_kill = 0;
    if (wa) aux_req = 0;
    else core_req = 0;
  endtask

  task automatic new_core();
    core_req = 1; core_op = OPW'($urandom); core_aop = $urandom; core_bop = $urandom;
  endtask

  task automatic new_aux();
    aux_req = 1; aux_op = OPW'($urandom); aux_aop = $urandom; aux_bop = $urandom;
  endtask

  initial begin
    int k;
    core_op = '0; core_aop = '0; core_bop = '0; aux_op = '0; aux_aop = '0; aux_bop = '0; ce_rin = '0;
    do_reset(0);
    new_core();
    txn(4, 0, 0, 32'h1234_5678);
    do_reset(0);
    new_core(); new_aux();
    txn(3, 0, 0, 32'h0BAD_F00D);
    txn(3, 0, 0, 32'hA5A5_0001);
    new_core(); new_aux();
    txn(2, 0, 1, 32'h7777_8888);
    txn(5, 0, 1, 32'h1111_2222);
    new_core(); new_aux();
    txn(6, 3, 0, 32'hFFFF_0000);
    txn(2, 0, 0, 32'h3333_4444);
    new_core();
    txn(4, 4, 0, 32'hDEAD_BEEF);
    new_aux();
    txn(0, 0, 0, '0);
    err_clr = 1;
    #1;
    cyc_chk("clr0", 0, 0, 0, 0, 0);
    tick();
    err_clr = 0; exp_err = 0;
    #1;
    cyc_chk("clr1", 0, 0, 0, 0, 0);
    new_aux();
    err_clr = 1;
    txn(0, 0, 0, '0);
    err_clr = 0; exp_err = 0;
    #1;
    cyc_chk("clr2", 0, 0, 0, 0, 0);
    new_core();
    #1;
    cyc_chk("r6.grant", 0, 0, 0, 0, 0);
    tick();
    #1;
    cyc_chk("r6.start", 1, 0, 0, 0, 0);
    tick();
    do_reset(1);
    new_core();
    txn(2, 0, 0, 32'h0000_00C3);
    for (int n = 0; n < 60; n++) begin
      if (!core_req && $urandom_range(0, 1) == 1) new_core();
      if (!aux_req && $urandom_range(0, 1) == 1) new_aux();
      if (!core_req && !aux_req) begin
        #1;
        cyc_chk("idle", 0, 0, 0, 0, 0);
        tick();
      end else begin
        k = $urandom_range(2, 6);
        txn(k, ($urandom_range(0, 3) == 0) ? $urandom_range(2, k) : 0,
            $urandom_range(0, 1) == 1, $urandom);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
